// File: rtl/mem_snoop_responder_if.sv
// Snoop bus port bundle between the bus fabric and the memory responder.
// The fabric drives the bus word and handshakes; the responder returns status.
interface mem_snoop_responder_if;
   logic [7:0] InBus;
   logic       grant;
   logic       cache_hit;
   logic [7:0] q;
   logic       busy;
   logic       wb_done;
   logic       err;

   modport master (
      output InBus, grant, cache_hit,
      input  q, busy, wb_done, err
   );

   modport slave (
      input  InBus, grant, cache_hit,
      output q, busy, wb_done, err
   );
endinterface

// File: rtl/mem_snoop_responder.sv
// Memory-side snoop responder: services read misses after a fixed latency
// and absorbs write-backs into a 4x4 store, with a one-deep request queue.
module mem_snoop_responder #(
   parameter logic [1:0]  ReadMiss  = 2'd1,
   parameter logic [1:0]  ReadHit   = 2'd2,
   parameter logic [1:0]  WriteBack = 2'd3,
   parameter int unsigned LAT       = 2,
   parameter logic [15:0] INIT_VAL  = 16'h4321
) (
   input logic                  clock,
   input logic                  resetn,
   mem_snoop_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, REPLY} state_t;

   localparam logic [2:0] LOAD = 3'(LAT - 1);

   state_t     state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [1:0] tag, tag_n;
   logic       qv, qv_n;
   logic [1:0] qtag, qtag_n;
   logic [7:0] q_n;
   logic       err_n;
   logic [3:0] mem [4];

   logic [1:0] msg, itag, stag;
   logic [3:0] ival;
   logic       rm, wb, fin, start;

   assign msg  = bus.InBus[7:6];
   assign itag = bus.InBus[5:4];
   assign ival = bus.InBus[3:0];
   assign rm   = (msg == ReadMiss);
   assign wb   = (msg == WriteBack);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tag_n   = tag;
      qv_n    = qv;
      qtag_n  = qtag;
      q_n     = bus.q;
      err_n   = bus.err;
      fin     = 1'b0;
      start   = 1'b0;
      stag    = qtag;

      unique case (state)
         IDLE: begin
            if (qv) begin
               start = 1'b1;
               stag  = qtag;
               qv_n  = rm;
               if (rm) qtag_n = itag;
            end else if (rm) begin
               start = 1'b1;
               stag  = itag;
            end
         end
         WAIT: begin
            if (bus.cache_hit) begin
               fin = 1'b1;
            end else if (cnt == 3'd1) begin
               state_n = REPLY;
               q_n = {ReadHit, tag,
                      (wb && itag == tag) ? ival : mem[tag]};
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         REPLY: begin
            if (bus.grant || bus.cache_hit) begin
               fin = 1'b1;
            end else if (wb && itag == tag) begin
               q_n = {ReadHit, tag, ival};
            end
         end
         default: state_n = IDLE;
      endcase

      // Requests arriving while busy wait in the single queue slot
      if (state != IDLE && rm) begin
         if (qv) begin
            err_n = 1'b1;
         end else begin
            qv_n   = 1'b1;
            qtag_n = itag;
         end
      end

      if (fin) begin
         q_n     = 8'h00;
         state_n = IDLE;
         if (qv) begin
            start = 1'b1;
            stag  = qtag;
            qv_n  = 1'b0;
         end
      end

      if (start) begin
         tag_n = stag;
         if (LAT == 1) begin
            state_n = REPLY;
            q_n = {ReadHit, stag,
                   (wb && itag == stag) ? ival : mem[stag]};
         end else begin
            state_n = WAIT;
            cnt_n   = LOAD;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         tag         <= 2'd0;
         qv          <= 1'b0;
         qtag        <= 2'd0;
         bus.q       <= 8'h00;
         bus.busy    <= 1'b0;
         bus.wb_done <= 1'b0;
         bus.err     <= 1'b0;
         for (int i = 0; i < 4; i++) mem[i] <= INIT_VAL[4*i +: 4];
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         tag         <= tag_n;
         qv          <= qv_n;
         qtag        <= qtag_n;
         bus.q       <= q_n;
         bus.err     <= err_n;
         bus.wb_done <= wb;
         bus.busy    <= (state_n != IDLE) || qv_n;
         if (wb) mem[itag] <= ival;
      end
   end

endmodule
